// File: rtl/sub4_serial.sv
// Bit-serial subtractor: diff = a - b - i_b, one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
module sub4_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             i_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             o_b
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_o_b;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_br_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_o_b_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_cell;
    logic [WIDTH:0]   w_res_ext;
    logic [WIDTH-1:0] w_res_shift;
    logic             w_last;

    // Full-subtractor cell on the current LSBs and the borrow flop
    assign w_x         = r_a[0];
    assign w_y         = r_b[0];
    assign w_d         = w_x ^ w_y ^ r_br;
    assign w_br_cell   = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
    // Difference bit enters at the MSB; written this way so WIDTH=1 needs no empty slice
    assign w_res_ext   = {w_d, r_res};
    assign w_res_shift = w_res_ext[WIDTH:1];
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_br_nxt    = r_br;
        w_cnt_nxt   = r_cnt;
        w_diff_nxt  = r_diff;
        w_o_b_nxt   = r_o_b;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_br_nxt    = i_b;
                    w_res_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                w_a_nxt   = r_a >> 1;
                w_b_nxt   = r_b >> 1;
                w_res_nxt = w_res_shift;
                w_br_nxt  = w_br_cell;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_diff_nxt  = w_res_shift;
                    w_o_b_nxt   = w_br_cell;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == SHIFT);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_o_b   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_res   <= w_res_nxt;
            r_br    <= w_br_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_diff  <= w_diff_nxt;
            r_o_b   <= w_o_b_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign o_b  = r_o_b;

endmodule
